// File: rtl/alu_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_if
// Instruction/result bus between an upstream instruction source and the
// alu_issue_ctrl controller.
//   in_valid / in_instr / in_ready : valid/ready instruction handshake
//   done / result / flags / err    : writeback status reported by the controller
// modport master : instruction source (drives the instruction, observes status)
// modport slave  : controller (accepts the instruction, drives status)
// ---------------------------------------------------------------------------
interface alu_issue_ctrl_if;
    logic        in_valid;
    logic [11:0] in_instr;
    logic        in_ready;
    logic        done;
    logic [3:0]  result;
    logic [2:0]  flags;
    logic        err;

    modport master (
        output in_valid,
        output in_instr,
        input  in_ready,
        input  done,
        input  result,
        input  flags,
        input  err
    );

    modport slave (
        input  in_valid,
        input  in_instr,
        output in_ready,
        output done,
        output result,
        output flags,
        output err
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Control stage in front of a 4-bit combinational ALU. Accepts one 12-bit
// instruction at a time, reads operands from a 4 x 4-bit register file,
// drives the ALU, captures its result and flags, then writes back.
// Every accepted instruction takes exactly three cycles (IDLE -> EXEC -> WB).
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   up (slave modport)  in_valid/in_instr/in_ready handshake,
//                       done/result/flags/err writeback status
//   alu_a/alu_b/alu_sel operands and operation to the ALU (zero unless EXEC)
//   alu_out/alu_carry/alu_zero/alu_neg  combinational ALU response
//   dbg_addr/dbg_data   combinational register-file debug read
//
// Instruction layout: [11:8] op, [7:6] rd, [5:4] ra, [3:2] rb, [3:0] imm.
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter logic [3:0]  LDI_OP       = 4'b1111,
    parameter int unsigned TRAP_ILLEGAL = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_issue_ctrl_if.slave        up,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [3:0]             alu_sel,
    input  logic [3:0]             alu_out,
    input  logic                   alu_carry,
    input  logic                   alu_zero,
    input  logic                   alu_neg,
    input  logic [1:0]             dbg_addr,
    output logic [3:0]             dbg_data
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] instr_q, instr_d;
    logic [3:0]  res_q,   res_d;
    logic        c_q,     c_d;
    logic        z_q,     z_d;
    logic        n_q,     n_d;
    logic [3:0]  result_q, result_d;
    logic [2:0]  flags_q,  flags_d;
    logic [3:0]  rf_q [4];
    logic [3:0]  rf_d [4];

    logic        in_ready_c;
    logic        done_c;
    logic        err_c;
    logic [3:0]  alu_a_c;
    logic [3:0]  alu_b_c;
    logic [3:0]  alu_sel_c;

    // Fields of the latched instruction
    logic [3:0]  op;
    logic [1:0]  rd;
    logic [1:0]  ra;
    logic [1:0]  rb;
    logic [3:0]  imm;
    logic        legal;

    assign op  = instr_q[11:8];
    assign rd  = instr_q[7:6];
    assign ra  = instr_q[5:4];
    assign rb  = instr_q[3:2];
    assign imm = instr_q[3:0];

    function automatic logic is_legal(input logic [3:0] opc);
        logic ok;
        ok = (opc == OP_AND) || (opc == OP_OR)  || (opc == OP_ADD) ||
             (opc == OP_SUB) || (opc == OP_SLT) || (opc == OP_NOR) ||
             (opc == LDI_OP);
        return ok;
    endfunction

    assign legal = is_legal(op);

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        res_d      = res_q;
        c_d        = c_q;
        z_d        = z_q;
        n_d        = n_q;
        result_d   = result_q;
        flags_d    = flags_q;
        rf_d       = rf_q;
        in_ready_c = 1'b0;
        done_c     = 1'b0;
        err_c      = 1'b0;
        alu_a_c    = 4'h0;
        alu_b_c    = 4'h0;
        alu_sel_c  = 4'h0;

        case (state_q)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                if (up.in_valid) begin
                    instr_d = up.in_instr;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                // Operands are read here, one cycle before the writeback,
                // so rd aliasing ra/rb never sees a half-updated register.
                alu_a_c   = rf_q[ra];
                alu_b_c   = rf_q[rb];
                alu_sel_c = op;
                if (op == LDI_OP) begin
                    res_d = imm;
                    c_d   = 1'b0;
                    z_d   = (imm == 4'h0);
                    n_d   = imm[3];
                end else begin
                    res_d = alu_out;
                    // CarryOut only means something for ADD/SUB; for the
                    // other operations it is left over from earlier work.
                    c_d   = ((op == OP_ADD) || (op == OP_SUB)) ? alu_carry : 1'b0;
                    z_d   = alu_zero;
                    n_d   = alu_neg;
                end
                state_d = ST_WB;
            end

            ST_WB: begin
                done_c = 1'b1;
                if (legal) begin
                    rf_d[rd] = res_q;
                    result_d = res_q;
                    flags_d  = {c_q, z_q, n_q};
                end else if (TRAP_ILLEGAL != 0) begin
                    err_c = 1'b1;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            instr_q  <= 12'h000;
            res_q    <= 4'h0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            result_q <= 4'h0;
            flags_q  <= 3'b000;
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= 4'h0;
            end
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            res_q    <= res_d;
            c_q      <= c_d;
            z_q      <= z_d;
            n_q      <= n_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign up.in_ready = in_ready_c;
    assign up.done     = done_c;
    assign up.err      = err_c;
    assign up.result   = result_q;
    assign up.flags    = flags_q;

    assign alu_a    = alu_a_c;
    assign alu_b    = alu_b_c;
    assign alu_sel  = alu_sel_c;

    assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        tb_valid;
    logic [11:0] tb_instr;
    logic        sel;          // 0: trapping instance, 1: non-trapping instance
    logic [1:0]  dbg_addr;

    alu_issue_ctrl_if if0 ();
    alu_issue_ctrl_if if1 ();

    assign if0.in_valid = tb_valid && (sel == 1'b0);
    assign if1.in_valid = tb_valid && (sel == 1'b1);
    assign if0.in_instr = tb_instr;
    assign if1.in_instr = tb_instr;

    logic [3:0] a0, b0, s0, o0, dbg0;
    logic       c0, z0, n0;
    logic [3:0] a1, b1, s1, o1, dbg1;
    logic       c1, z1, n1;

    // Behavioural 4-bit ALU. CarryOut is forced to 1 for operations where it
    // carries no meaning, so a controller that forwards it gets caught.
    function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] s);
        logic [4:0] r;
        case (s)
            4'b0000: r = {1'b1, a & b};
            4'b0001: r = {1'b1, a | b};
            4'b0010: r = {1'b0, a} + {1'b0, b};
            4'b0110: r = {(a < b), 4'(a - b)};
            4'b0111: r = {1'b1, ((a < b) ? 4'h1 : 4'h0)};
            4'b1100: r = {1'b1, ~(a | b)};
            default: r = {1'b1, 4'hA};
        endcase
        return r;
    endfunction

    assign {c0, o0} = alu_model(a0, b0, s0);
    assign z0 = (o0 == 4'h0);
    assign n0 = o0[3];
    assign {c1, o1} = alu_model(a1, b1, s1);
    assign z1 = (o1 == 4'h0);
    assign n1 = o1[3];

    alu_issue_ctrl #(.LDI_OP(4'b1111), .TRAP_ILLEGAL(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .up(if0),
        .alu_a(a0), .alu_b(b0), .alu_sel(s0),
        .alu_out(o0), .alu_carry(c0), .alu_zero(z0), .alu_neg(n0),
        .dbg_addr(dbg_addr), .dbg_data(dbg0)
    );

    alu_issue_ctrl #(.LDI_OP(4'b1111), .TRAP_ILLEGAL(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .up(if1),
        .alu_a(a1), .alu_b(b1), .alu_sel(s1),
        .alu_out(o1), .alu_carry(c1), .alu_zero(z1), .alu_neg(n1),
        .dbg_addr(dbg_addr), .dbg_data(dbg1)
    );

    // Observed signals of the instance under test
    logic       o_ready, o_done, o_err;
    logic [3:0] o_result, o_dbg, o_a, o_b, o_s;
    logic [2:0] o_flags;
    assign o_ready  = sel ? if1.in_ready : if0.in_ready;
    assign o_done   = sel ? if1.done     : if0.done;
    assign o_err    = sel ? if1.err      : if0.err;
    assign o_result = sel ? if1.result   : if0.result;
    assign o_flags  = sel ? if1.flags    : if0.flags;
    assign o_dbg    = sel ? dbg1 : dbg0;
    assign o_a      = sel ? a1 : a0;
    assign o_b      = sel ? b1 : b0;
    assign o_s      = sel ? s1 : s0;

    typedef struct {
        logic [3:0] a, b, op, res, old_v, new_v;
        logic [2:0] flags;
        logic       err;
        logic [1:0] rd;
    } exp_t;

    exp_t sb[$];

    // Golden architectural state, one copy per instance
    logic [3:0] g_rf [2][4];
    logic [3:0] g_res [2];
    logic [2:0] g_flags [2];

    int n_assert = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;
    int acc_exp  = 0;
    int cyc      = 0;
    int done_cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && tb_valid && o_ready) acc_cnt <= acc_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ins(input logic [3:0] op, input logic [1:0] rd,
                                         input logic [1:0] ra, input logic [1:0] rb);
        return {op, rd, ra, rb, 2'b00};
    endfunction

    function automatic logic [11:0] ldi(input logic [1:0] rd, input logic [3:0] imm);
        return {4'b1111, rd, 2'b00, imm};
    endfunction

    task automatic golden_reset();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 4; r++) g_rf[d][r] = 4'h0;
            g_res[d]   = 4'h0;
            g_flags[d] = 3'b000;
        end
    endtask

    // Present an instruction and push what its writeback must look like.
    task automatic drive(input logic [11:0] instr);
        exp_t e;
        logic [3:0] op, a, b, r;
        logic [1:0] rd, ra, rb;
        logic c, lg;
        op = instr[11:8]; rd = instr[7:6]; ra = instr[5:4]; rb = instr[3:2];
        a = g_rf[sel][ra]; b = g_rf[sel][rb];
        c = 1'b0; r = 4'h0; lg = 1'b1;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: {c, r} = {1'b0, a} + {1'b0, b};
            4'h6: begin r = a - b; c = (a < b); end
            4'h7: r = (a < b) ? 4'h1 : 4'h0;
            4'hC: r = ~(a | b);
            4'hF: r = instr[3:0];
            default: lg = 1'b0;
        endcase
        e.a = a; e.b = b; e.op = op; e.rd = rd;
        e.old_v = g_rf[sel][rd];
        if (lg) begin
            g_rf[sel][rd] = r;
            g_res[sel]    = r;
            g_flags[sel]  = {c, (r == 4'h0), r[3]};
        end
        e.new_v = g_rf[sel][rd];
        e.res   = g_res[sel];
        e.flags = g_flags[sel];
        e.err   = !lg && (sel == 1'b0);
        sb.push_back(e);
        tb_instr = instr;
        tb_valid = 1'b1;
        acc_exp++;
    endtask

    // Called at a falling edge; returns at the falling edge inside EXEC.
    task automatic wait_accept();
        int k = 0;
        while (!o_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("accept_in_time", 32'(k < 10), 32'(1));
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at the EXEC falling edge; returns at the IDLE falling edge after WB.
    task automatic wait_done();
        exp_t e;
        int lat = 1;
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 32'(sb.size()), 32'(1));
            return;
        end
        e = sb.pop_front();
        chk("exec_ready", 32'(o_ready), 32'(0));
        chk("exec_done", 32'(o_done), 32'(0));
        chk("exec_alu_a", 32'(o_a), 32'(e.a));
        chk("exec_alu_b", 32'(o_b), 32'(e.b));
        chk("exec_alu_sel", 32'(o_s), 32'(e.op));
        while (!o_done && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk("done_latency", 32'(lat), 32'(2));
        done_cyc = cyc;
        chk("wb_err", 32'(o_err), 32'(e.err));
        chk("wb_ready", 32'(o_ready), 32'(0));
        chk("wb_alu_sel_zero", 32'(o_s), 32'(0));
        dbg_addr = e.rd;
        #1;
        chk("wb_dbg_before_write", 32'(o_dbg), 32'(e.old_v));
        @(negedge clk);
        chk("done_one_cycle", 32'(o_done), 32'(0));
        chk("err_one_cycle", 32'(o_err), 32'(0));
        chk("result", 32'(o_result), 32'(e.res));
        chk("flags", 32'(o_flags), 32'(e.flags));
        chk("dbg_after_write", 32'(o_dbg), 32'(e.new_v));
        chk("idle_ready", 32'(o_ready), 32'(1));
        $display("txn sel=%0d op=%h rd=%0d result=%h flags=%b err=%0d", sel, e.op, e.rd,
                 o_result, o_flags, e.err);
    endtask

    task automatic send(input logic [11:0] instr);
        drive(instr);
        wait_accept();
        tb_valid = 1'b0;
        wait_done();
    endtask

    task automatic check_rf_vs_golden(input string tag);
        for (int r = 0; r < 4; r++) begin
            dbg_addr = 2'(r);
            #1;
            chk(tag, 32'(o_dbg), 32'(g_rf[sel][r]));
        end
    endtask

    initial begin
        int t0, t1, t2;
        rst_n = 1'b0; tb_valid = 1'b0; tb_instr = 12'h000; sel = 1'b0; dbg_addr = 2'd0;
        golden_reset();
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ready", 32'(o_ready), 32'(1));
        chk("rst_done", 32'(o_done), 32'(0));
        chk("rst_err", 32'(o_err), 32'(0));
        chk("rst_result", 32'(o_result), 32'(0));
        chk("rst_flags", 32'(o_flags), 32'(0));
        chk("rst_alu_a", 32'(o_a), 32'(0));
        chk("rst_alu_b", 32'(o_b), 32'(0));
        chk("rst_alu_sel", 32'(o_s), 32'(0));
        check_rf_vs_golden("rst_rf");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back stream: in_valid held, new instruction presented during EXEC/WB
        drive(ldi(2'd1, 4'd9));
        wait_accept();
        drive(ldi(2'd2, 4'd8));
        wait_done();   t0 = done_cyc;
        wait_accept();
        drive(ins(4'b0010, 2'd3, 2'd1, 2'd2));
        wait_done();   t1 = done_cyc;
        wait_accept();
        tb_valid = 1'b0;
        wait_done();   t2 = done_cyc;
        chk("done_spacing_1", 32'(t1 - t0), 32'(3));
        chk("done_spacing_2", 32'(t2 - t1), 32'(3));
        dbg_addr = 2'd3; #1;
        chk("add_r3", 32'(o_dbg), 32'(4'h1));
        chk("add_flags", 32'(o_flags), 32'(3'b100));
        chk("stream_accepts", 32'(acc_cnt), 32'(acc_exp));

        // SUB with borrow, SLT, SUB to zero
        send(ldi(2'd1, 4'd3));
        send(ldi(2'd2, 4'd5));
        send(ins(4'b0110, 2'd0, 2'd1, 2'd2));
        chk("sub_result", 32'(o_result), 32'(4'hE));
        chk("sub_flags", 32'(o_flags), 32'(3'b101));
        send(ins(4'b0111, 2'd3, 2'd1, 2'd2));
        chk("slt_result", 32'(o_result), 32'(4'h1));
        chk("slt_flags", 32'(o_flags), 32'(3'b000));
        send(ins(4'b0110, 2'd1, 2'd1, 2'd1));
        chk("subz_result", 32'(o_result), 32'(4'h0));
        chk("subz_flags", 32'(o_flags), 32'(3'b010));

        // Illegal opcode, trapping instance
        send(ldi(2'd2, 4'd5));
        send(ins(4'b0011, 2'd2, 2'd1, 2'd1));
        chk("trap_result_kept", 32'(o_result), 32'(4'h5));
        chk("trap_r2_kept", 32'(o_dbg), 32'(4'h5));

        // Illegal opcode, non-trapping instance
        sel = 1'b1;
        @(negedge clk);
        send(ldi(2'd2, 4'd5));
        send(ins(4'b0011, 2'd2, 2'd1, 2'd1));
        chk("nop_result_kept", 32'(o_result), 32'(4'h5));
        check_rf_vs_golden("nop_rf");
        sel = 1'b0;
        @(negedge clk);

        // Backpressure: second instruction waits for IDLE, accepted once
        drive(ldi(2'd0, 4'd4));
        wait_accept();
        drive(ins(4'b1100, 2'd1, 2'd0, 2'd2));
        wait_done();
        wait_accept();
        tb_valid = 1'b0;
        wait_done();
        repeat (2) @(negedge clk);
        chk("bp_accepts", 32'(acc_cnt), 32'(acc_exp));
        check_rf_vs_golden("bp_rf");

        // Reset while an ADD into r2 (holding 7) is in EXEC
        send(ldi(2'd2, 4'd7));
        tb_instr = ins(4'b0010, 2'd2, 2'd1, 2'd1);
        tb_valid = 1'b1;
        acc_exp++;
        wait_accept();
        tb_valid = 1'b0;
        rst_n = 1'b0;
        golden_reset();
        #1;
        chk("abort_ready", 32'(o_ready), 32'(1));
        chk("abort_done", 32'(o_done), 32'(0));
        check_rf_vs_golden("abort_rf");
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done", 32'(o_done), 32'(0));
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_done", 32'(o_done), 32'(0));
            chk("post_rst_ready", 32'(o_ready), 32'(1));
        end
        chk("post_rst_result", 32'(o_result), 32'(0));
        check_rf_vs_golden("post_rst_rf");

        // Operand aliasing
        send(ldi(2'd1, 4'd6));
        send(ins(4'b0010, 2'd1, 2'd1, 2'd1));
        chk("alias_r1", 32'(o_dbg), 32'(4'hC));
        chk("alias_flags", 32'(o_flags), 32'(3'b001));

        chk("final_accepts", 32'(acc_cnt), 32'(acc_exp));
        chk("scoreboard_empty", 32'(sb.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
